// File: rtl/axi4_lite_write_arbiter.sv
// axi4_lite_write_arbiter
// Two requesters share one AXI4-Lite write master port. Requesters are
// arbitrated round-robin, and each transaction runs through four states:
// IDLE, SEND, RESP and DONE.
//
// Optional watchdog: define AXIL_WR_TIMEOUT_EN to abort a stalled SEND/RESP
// phase after TIMEOUT_CYCLES cycles. An aborted transaction reports
// resp_OUT = 2'b11. With the macro undefined, SEND and RESP wait forever.
//
// Handshake rule on every channel: a transfer happens on a rising ACLK edge
// where VALID and READY are both high. Once a VALID has been raised, it and
// its payload are held until that edge, then dropped on the next cycle.
module axi4_lite_write_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    req0_VALID,
   input  logic [ADDR_WIDTH-1:0]   req0_ADDR,
   input  logic [DATA_WIDTH-1:0]   req0_DATA,
   output logic                    req0_ACK,
   output logic                    req0_DONE,
   input  logic                    req1_VALID,
   input  logic [ADDR_WIDTH-1:0]   req1_ADDR,
   input  logic [DATA_WIDTH-1:0]   req1_DATA,
   output logic                    req1_ACK,
   output logic                    req1_DONE,
   output logic [1:0]              resp_OUT,
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic [2:0]              AWPROT,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [DATA_WIDTH-1:0]   WDATA,
   output logic [DATA_WIDTH/8-1:0] WSTRB,
   output logic                    WVALID,
   input  logic                    WREADY,
   input  logic [1:0]              BRESP,
   input  logic                    BVALID,
   output logic                    BREADY,
   output logic                    busy_OUT,
   output logic [1:0]              dbg_state_o
);

   localparam int SW = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                  state_q;
   logic                    last_q;      // requester granted most recently
   logic                    gnt_q;       // requester owning the current transaction
   logic                    aw_valid_q;
   logic                    w_valid_q;
   logic                    aw_done_q;
   logic                    w_done_q;
   logic                    bready_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [SW-1:0]           strb_q;
   logic [1:0]              resp_q;

   logic                    gnt_any;
   logic                    gnt_d;
   logic                    aw_hs;
   logic                    w_hs;
   logic                    aw_fin;
   logic                    w_fin;

`ifdef AXIL_WR_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]           cnt_q;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   // Round-robin pick. When both requesters are valid, the one not granted
   // last time wins. No grant is made while reset is held.
   always_comb begin
      gnt_any = 1'b0;
      gnt_d   = 1'b0;
      if (state_q == S_IDLE && !ARESET) begin
         gnt_any = req0_VALID | req1_VALID;
         gnt_d   = (req0_VALID & req1_VALID) ? ~last_q : req1_VALID;
      end
   end

   assign aw_hs  = aw_valid_q & AWREADY;
   assign w_hs   = w_valid_q & WREADY;
   assign aw_fin = aw_done_q | aw_hs;
   assign w_fin  = w_done_q | w_hs;

   // Transaction FSM. Every bus-facing control bit and payload is a flop.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q    <= S_IDLE;
         last_q     <= 1'b1;
         gnt_q      <= 1'b0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         bready_q   <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         strb_q     <= '0;
         resp_q     <= 2'b00;
`ifdef AXIL_WR_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (gnt_any) begin
                  state_q    <= S_SEND;
                  gnt_q      <= gnt_d;
                  last_q     <= gnt_d;
                  addr_q     <= gnt_d ? req1_ADDR : req0_ADDR;
                  data_q     <= gnt_d ? req1_DATA : req0_DATA;
                  strb_q     <= '1;
                  aw_valid_q <= 1'b1;
                  w_valid_q  <= 1'b1;
                  aw_done_q  <= 1'b0;
                  w_done_q   <= 1'b0;
`ifdef AXIL_WR_TIMEOUT_EN
                  cnt_q      <= '0;
`endif
               end
            end
            S_SEND: begin
               if (aw_hs) begin
                  aw_valid_q <= 1'b0;
                  aw_done_q  <= 1'b1;
               end
               if (w_hs) begin
                  w_valid_q <= 1'b0;
                  w_done_q  <= 1'b1;
               end
               if (aw_fin && w_fin) begin
                  state_q  <= S_RESP;
                  bready_q <= 1'b1;
               end
`ifdef AXIL_WR_TIMEOUT_EN
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                  aw_valid_q <= 1'b0;
                  w_valid_q  <= 1'b0;
                  bready_q   <= 1'b0;
                  resp_q     <= 2'b11;
                  state_q    <= S_DONE;
               end
`endif
            end
            S_RESP: begin
               if (BVALID && bready_q) begin
                  resp_q   <= BRESP;
                  bready_q <= 1'b0;
                  state_q  <= S_DONE;
               end
`ifdef AXIL_WR_TIMEOUT_EN
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                  bready_q <= 1'b0;
                  resp_q   <= 2'b11;
                  state_q  <= S_DONE;
               end
`endif
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // The ACK is decoded in the grant cycle itself so that AW/W valid can
   // follow on the next cycle. Everything else comes straight from flops.
   assign req0_ACK    = gnt_any & ~gnt_d;
   assign req1_ACK    = gnt_any & gnt_d;
   assign req0_DONE   = (state_q == S_DONE) & ~gnt_q;
   assign req1_DONE   = (state_q == S_DONE) & gnt_q;
   assign resp_OUT    = (state_q == S_DONE) ? resp_q : 2'b00;
   assign AWADDR      = addr_q;
   assign AWPROT      = 3'b000;
   assign AWVALID     = aw_valid_q;
   assign WDATA       = data_q;
   assign WSTRB       = strb_q;
   assign WVALID      = w_valid_q;
   assign BREADY      = bready_q;
   assign busy_OUT    = (state_q != S_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi4_lite_write_arbiter.sv
// Directed bench for axi4_lite_write_arbiter (default build, watchdog off).
// Completed writes are predicted into exp_q when a request is issued and
// popped when reqN_DONE appears.
module tb_axi4_lite_write_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int EW = 1 + 2 + AW + DW;

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic          req0_VALID, req1_VALID;
   logic [AW-1:0] req0_ADDR, req1_ADDR;
   logic [DW-1:0] req0_DATA, req1_DATA;
   logic          req0_ACK, req1_ACK, req0_DONE, req1_DONE;
   logic [1:0]    resp_OUT;
   logic [AW-1:0] AWADDR;
   logic [2:0]    AWPROT;
   logic          AWVALID, AWREADY;
   logic [DW-1:0] WDATA;
   logic [3:0]    WSTRB;
   logic          WVALID, WREADY;
   logic [1:0]    BRESP;
   logic          BVALID, BREADY;
   logic          busy_OUT;
   logic [1:0]    dbg_state;

   axi4_lite_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .req0_VALID(req0_VALID), .req0_ADDR(req0_ADDR), .req0_DATA(req0_DATA),
      .req0_ACK(req0_ACK), .req0_DONE(req0_DONE),
      .req1_VALID(req1_VALID), .req1_ADDR(req1_ADDR), .req1_DATA(req1_DATA),
      .req1_ACK(req1_ACK), .req1_DONE(req1_DONE),
      .resp_OUT(resp_OUT),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .busy_OUT(busy_OUT), .dbg_state_o(dbg_state)
   );

   // clock / cycle counter
   always #5 ACLK = ~ACLK;
   int cyc = 0;
   always @(posedge ACLK) cyc++;

   int total = 0;
   int bad   = 0;
   logic [EW-1:0] exp_q[$];
   logic          chk_lat = 1'b0;
   int            ack_cyc = 0;
   logic [AW-1:0] seen_addr = '0;
   logic [DW-1:0] seen_data = '0;
   logic          aw_wait_prev = 1'b0;
   logic [AW-1:0] aw_prev = '0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   // scoreboard / bus monitor, sampled on the falling edge
   always @(negedge ACLK) begin
      logic [EW-1:0] e;
      if (!ARESET) begin
         if (req0_ACK || req1_ACK) begin
            check("ack_excl", 128'(req0_ACK & req1_ACK), 128'd0);
            ack_cyc = cyc;
         end
         if (aw_wait_prev && AWVALID) check("aw_stable", 128'(AWADDR), 128'(aw_prev));
         if (AWVALID && AWREADY) begin
            seen_addr = AWADDR;
            check("awprot", 128'(AWPROT), 128'd0);
         end
         if (WVALID && WREADY) begin
            seen_data = WDATA;
            check("wstrb", 128'(WSTRB), 128'hF);
         end
         if (req0_DONE || req1_DONE) begin
            check("done_excl", 128'(req0_DONE & req1_DONE), 128'd0);
            if (exp_q.size() == 0) begin
               check("done_unexpected", 128'd1, 128'd0);
            end else begin
               e = exp_q.pop_front();
               check("done_pkt", 128'({req1_DONE, resp_OUT, seen_addr, seen_data}), 128'(e));
               if (chk_lat) check("ack_to_done", 128'(cyc - ack_cyc), 128'd3);
            end
         end else begin
            check("resp_idle", 128'(resp_OUT), 128'd0);
         end
      end
      aw_wait_prev = AWVALID && !AWREADY && !ARESET;
      aw_prev      = AWADDR;
   end

   // driver tasks
   task automatic wait_any_ack(output int got, input int budget);
      got = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge ACLK);
         if (req0_ACK) begin got = 0; break; end
         if (req1_ACK) begin got = 1; break; end
      end
   endtask

   task automatic wait_idle(input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge ACLK);
         if (!busy_OUT) begin ok = 1'b1; break; end
      end
      check("idle_wait", 128'(ok), 128'd1);
   endtask

   // Issues one write; returns at the start of the cycle after the grant.
   task automatic send(input logic id, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [1:0] r, input bit push);
      int got;
      if (push) exp_q.push_back({id, r, a, d});
      @(posedge ACLK); #1;
      if (id) begin req1_VALID = 1'b1; req1_ADDR = a; req1_DATA = d; end
      else    begin req0_VALID = 1'b1; req0_ADDR = a; req0_DATA = d; end
      wait_any_ack(got, 20);
      check("ack_id", 128'(got), 128'(int'(id)));
      @(posedge ACLK); #1;
      req0_VALID = 1'b0;
      req1_VALID = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, 128'({AWVALID, WVALID, BREADY, req0_ACK, req1_ACK, req0_DONE, req1_DONE,
                       resp_OUT, busy_OUT, AWADDR, WDATA, WSTRB, AWPROT}), 128'd0);
   endtask

   initial begin
      int got;
      int ord [4];
      int n0, n1;
      ord = '{0, 1, 0, 1};
      ARESET = 1'b1;
      req0_VALID = 1'b0; req1_VALID = 1'b0;
      req0_ADDR = '0; req0_DATA = '0; req1_ADDR = '0; req1_DATA = '0;
      AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check_all_zero("reset_outputs");
      @(posedge ACLK); #1 ARESET = 1'b0;

      // Contention: req0 wins first after reset, then strict alternation.
      chk_lat = 1'b1;
      exp_q.push_back({1'b0, 2'b00, 32'h0000_0100, 32'h1111_0000});
      exp_q.push_back({1'b1, 2'b00, 32'h0000_0200, 32'h2222_0000});
      exp_q.push_back({1'b0, 2'b00, 32'h0000_0104, 32'h1111_0001});
      exp_q.push_back({1'b1, 2'b00, 32'h0000_0204, 32'h2222_0001});
      @(posedge ACLK); #1;
      req0_VALID = 1'b1; req0_ADDR = 32'h100; req0_DATA = 32'h1111_0000;
      req1_VALID = 1'b1; req1_ADDR = 32'h200; req1_DATA = 32'h2222_0000;
      n0 = 0; n1 = 0;
      for (int k = 0; k < 4; k++) begin
         wait_any_ack(got, 30);
         check("rr_order", 128'(got), 128'(ord[k]));
         @(posedge ACLK); #1;
         if (got == 0) begin
            if (n0 == 0) begin req0_ADDR = 32'h104; req0_DATA = 32'h1111_0001; end
            else req0_VALID = 1'b0;
            n0++;
         end else if (got == 1) begin
            if (n1 == 0) begin req1_ADDR = 32'h204; req1_DATA = 32'h2222_0001; end
            else req1_VALID = 1'b0;
            n1++;
         end
      end
      req0_VALID = 1'b0; req1_VALID = 1'b0;
      wait_idle(20);

      // Single req0 write with all slave readies high.
      send(1'b0, 32'h10, 32'hDEAD_BEEF, 2'b00, 1'b1);
      @(negedge ACLK);
      check("t1_send", 128'({AWVALID, WVALID, AWADDR, WDATA, WSTRB}),
            128'({1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF}));
      @(negedge ACLK);
      check("t1_resp", 128'({AWVALID, WVALID, BREADY}), 128'(3'b001));
      wait_idle(20);

      // W completes four cycles before AW.
      chk_lat = 1'b0;
      AWREADY = 1'b0;
      send(1'b1, 32'h20, 32'h1234_5678, 2'b00, 1'b1);
      @(negedge ACLK);
      check("t3_first", 128'({AWVALID, WVALID, BREADY}), 128'(3'b110));
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         check("t3_aw_held", 128'({AWVALID, WVALID, BREADY}), 128'(3'b100));
      end
      @(posedge ACLK); #1 AWREADY = 1'b1;
      @(negedge ACLK);
      check("t3_aw_hs", 128'({AWVALID, WVALID, BREADY}), 128'(3'b100));
      @(negedge ACLK);
      check("t3_bready", 128'({AWVALID, WVALID, BREADY}), 128'(3'b001));
      wait_idle(20);

      // Error responses are passed through with the owner's DONE.
      chk_lat = 1'b1;
      BRESP = 2'b10;
      send(1'b1, 32'h30, 32'hCAFE_F00D, 2'b10, 1'b1);
      wait_idle(20);
      BRESP = 2'b01;
      send(1'b0, 32'h34, 32'h0BAD_CAFE, 2'b01, 1'b1);
      wait_idle(20);
      BRESP = 2'b00;

      // Reset in the middle of SEND: no DONE, then a clean request.
      chk_lat = 1'b0;
      AWREADY = 1'b0;
      send(1'b1, 32'h40, 32'h0BAD_0BAD, 2'b00, 1'b0);
      @(posedge ACLK); #1;
      ARESET = 1'b1;
      AWREADY = 1'b1;
      req0_VALID = 1'b1; req0_ADDR = 32'h50; req0_DATA = 32'h5555_AAAA;
      exp_q.push_back({1'b0, 2'b00, 32'h50, 32'h5555_AAAA});
      @(posedge ACLK);
      @(negedge ACLK);
      check_all_zero("reset_mid_send");
      @(posedge ACLK); #1 ARESET = 1'b0;
      chk_lat = 1'b1;
      wait_any_ack(got, 10);
      check("post_reset_ack", 128'(got), 128'd0);
      @(posedge ACLK); #1 req0_VALID = 1'b0;
      wait_idle(20);

      // Without the watchdog a stuck AWREADY holds AWVALID indefinitely.
      chk_lat = 1'b0;
      AWREADY = 1'b0;
      send(1'b0, 32'h60, 32'h6666_6666, 2'b00, 1'b1);
      repeat (40) @(negedge ACLK);
      check("aw_hold", 128'({AWVALID, busy_OUT, req0_DONE, BREADY}), 128'(4'b1100));
      @(posedge ACLK); #1 AWREADY = 1'b1;
      wait_idle(20);

      check("queue_empty", 128'(exp_q.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi4_lite_write_arbiter.md
AXI4_LITE_WRITE_ARBITER -- requirements
Module: axi4_lite_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width (multiple of 8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit; used only when AXIL_WR_TIMEOUT_EN is defined.
REQ-004 SHALL have one clock; reset is synchronous and active-high: ACLK  in  1  clock, all logic on rising edge.
REQ-005 SHALL have ARESET  in  1  synchronous active-high reset.
REQ-006 SHALL have req0_VALID / req1_VALID  in  1  requester N has a write pending.
REQ-007 SHALL have req0_ADDR / req1_ADDR  in  ADDR_WIDTH  write address of requester N.
REQ-008 SHALL have req0_DATA / req1_DATA  in  DATA_WIDTH  write data of requester N.
REQ-009 SHALL have req0_ACK / req1_ACK  out  1  one-cycle pulse: request N captured.
REQ-010 SHALL have req0_DONE / req1_DONE  out  1  one-cycle pulse: write N completed.
REQ-011 SHALL have resp_OUT  out  2  response for the write that completed, valid with reqN_DONE.
REQ-012 SHALL have AWADDR out ADDR_WIDTH, AWPROT out 3, AWVALID out 1, AWREADY in 1: AXI4-Lite write address channel.
REQ-013 SHALL have WDATA out DATA_WIDTH, WSTRB out DATA_WIDTH/8, WVALID out 1, WREADY in 1: write data channel.
REQ-014 SHALL have BRESP in 2, BVALID in 1, BREADY out 1: write response channel.
REQ-015 SHALL have busy_OUT  out  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SEND, RESP, DONE.
REQ-017 IDLE: if any reqN_VALID, SHALL grant one, register its ADDR/DATA, pulse reqN_ACK in that cycle, go to SEND.
REQ-018 Arbitration SHALL be round-robin: both valid -> grant the requester not granted last; last_grant resets to 1, so req0 wins first contention.
REQ-019 SEND: AWVALID and WVALID SHALL rise in the cycle after the grant, together; WSTRB all ones, AWPROT 3'b000.
REQ-020 Each of AWVALID/WVALID SHALL drop independently the cycle after its own handshake; AW and W completing in either order or same cycle SHALL all be legal.
REQ-021 When both AW and W handshakes have completed, SHALL enter RESP with BREADY high.
REQ-022 RESP: on BVALID&&BREADY SHALL capture BRESP, drop BREADY, go to DONE.
REQ-023 DONE: SHALL pulse granted reqN_DONE with resp_OUT = captured BRESP for exactly one cycle, then return to IDLE; no grant in DONE.
REQ-024 Minimum grant-to-DONE latency with AWREADY, WREADY, BVALID tied high: grant cycle N, AW/W valid N+1, BREADY N+2, DONE N+3.
REQ-025 AWADDR/WDATA SHALL stay stable while their VALID is high; reqN_VALID changes after ACK SHALL be ignored.
REQ-026 resp_OUT SHALL be 0 outside the DONE cycle; all reqN_ACK/reqN_DONE pulses SHALL be mutually exclusive between requesters.

Reset
REQ-027 ARESET high at any clock edge, including mid-transaction, SHALL force IDLE, last_grant=1, timeout counter 0, and all outputs 0 (AWVALID, WVALID, BREADY, ACK, DONE, resp_OUT, busy_OUT, AWADDR, WDATA, WSTRB, AWPROT).
REQ-028 A transaction aborted by reset SHALL produce no reqN_DONE.

Configuration
REQ-029 With AXIL_WR_TIMEOUT_EN defined: counter SHALL clear on grant, increment each SEND/RESP cycle; on reaching TIMEOUT_CYCLES SHALL drop AWVALID, WVALID, BREADY and go to DONE with resp_OUT=2'b11.
REQ-030 Without AXIL_WR_TIMEOUT_EN: no counter logic; SEND/RESP SHALL wait indefinitely.

Verification
REQ-031 req0 only, ADDR=0x10, DATA=0xDEADBEEF, slave readies high -> AWADDR=0x10, WDATA=0xDEADBEEF, WSTRB=0xF, req0_DONE 3 cycles after ACK, resp_OUT=0.
REQ-032 req0 and req1 valid together for three writes -> grants req0, req1, req0; never two ACKs in one cycle.
REQ-033 WREADY asserted 4 cycles before AWREADY -> WVALID drops first, AWVALID held, BREADY only after AW handshake.
REQ-034 BRESP=2'b10 on response -> resp_OUT=2'b10 with the granted requester's DONE.
REQ-035 ARESET pulsed during SEND -> next cycle all outputs 0, no DONE, next request accepted normally.
REQ-036 AXIL_WR_TIMEOUT_EN, TIMEOUT_CYCLES=8, AWREADY stuck low -> DONE with resp_OUT=2'b11 after 8 cycles; macro undefined -> AWVALID held indefinitely.
